// File: rtl/indexed_bit_register.sv
// Bit-vector register driven by indexed SET/CLR/TOGGLE/SWEEP commands with out-of-range flagging.
// Optional error counter: define INDEXED_BIT_REGISTER_ERR_CNT_EN to implement err_cnt (else tied to 0).
module indexed_bit_register #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic             err_clr,
    output logic [WIDTH-1:0] thing,
    output logic             busy,
    output logic             err,
    output logic [IDX_W-1:0] err_idx,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_CLR    = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_SWEEP  = 2'b11;

    // One extra bit so WIDTH == 2**IDX_W is representable without wrapping.
    localparam logic [IDX_W:0]   LIMIT    = (IDX_W+1)'(WIDTH);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_thing;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;
    logic             r_err;
    logic [IDX_W-1:0] r_errIdx;

    logic             w_accept;
    logic             w_inRange;
    logic             w_badCmd;
    logic [WIDTH-1:0] w_cmdMask;
    logic [WIDTH-1:0] w_ptrMask;

    assign cmd_ready = (r_state == IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_inRange = ({1'b0, cmd_idx} < LIMIT);
    assign w_badCmd  = w_accept && (cmd_op != OP_SWEEP) && !w_inRange;
    assign w_cmdMask = WIDTH'(1) << cmd_idx;
    assign w_ptrMask = WIDTH'(1) << r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_thing <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_SET:    if (w_inRange) r_thing <= r_thing | w_cmdMask;
                            OP_CLR:    if (w_inRange) r_thing <= r_thing & ~w_cmdMask;
                            OP_TOGGLE: if (w_inRange) r_thing <= r_thing ^ w_cmdMask;
                            OP_SWEEP: begin
                                r_state <= SWEEP;
                                r_ptr   <= '0;
                                r_busy  <= 1'b1;
                            end
                        endcase
                    end
                end
                SWEEP: begin
                    r_thing <= r_thing & ~w_ptrMask;
                    if (r_ptr == LAST_PTR) begin
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    // A new error on the same edge as err_clr wins and restarts the capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err    <= 1'b0;
            r_errIdx <= '0;
        end else if (w_badCmd) begin
            r_err <= 1'b1;
            if (!r_err || err_clr) r_errIdx <= cmd_idx;
        end else if (err_clr) begin
            r_err    <= 1'b0;
            r_errIdx <= '0;
        end
    end

`ifdef INDEXED_BIT_REGISTER_ERR_CNT_EN
    logic [CNT_W-1:0] r_errCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_errCnt <= '0;
        end else if (w_badCmd) begin
            if (err_clr)            r_errCnt <= CNT_W'(1);
            else if (r_errCnt != '1) r_errCnt <= r_errCnt + CNT_W'(1);
        end else if (err_clr) begin
            r_errCnt <= '0;
        end
    end

    assign err_cnt = r_errCnt;
`else
    assign err_cnt = '0;
`endif

    assign thing   = r_thing;
    assign busy    = r_busy;
    assign err     = r_err;
    assign err_idx = r_errIdx;

endmodule
